// File: rtl/laser_unit.sv
// Player laser for the play screen: launches from the ship on a shoot press,
// moves up once per frame, tests for a hit on the target box and draws itself.
module laser_unit #(
    parameter int          LASER_W         = 2,
    parameter int          LASER_H         = 8,
    parameter int          LASER_SPEED     = 4,
    parameter int          SHIP_W          = 16,
    parameter int          TARGET_W        = 16,
    parameter int          TARGET_H        = 16,
    parameter int          COOLDOWN_FRAMES = 15,
    parameter logic [7:0]  LASER_RGB       = 8'b000_111_00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       enable,
    input  logic       shoot,
    input  logic [9:0] ship_x,
    input  logic [9:0] ship_y,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    input  logic       target_alive,
    output logic [7:0] laser_color,
    output logic       laser_active,
    output logic       hit,
    output logic [7:0] shots_fired
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Geometry constants; 11-bit versions keep rectangle edges from wrapping.
    localparam logic [9:0]  LAUNCH_DX  = 10'(SHIP_W / 2 - LASER_W / 2);
    localparam logic [9:0]  LASER_H10  = 10'(LASER_H);
    localparam logic [9:0]  SPEED10    = 10'(LASER_SPEED);
    localparam logic [10:0] LASER_W11  = 11'(LASER_W);
    localparam logic [10:0] LASER_H11  = 11'(LASER_H);
    localparam logic [10:0] TARGET_W11 = 11'(TARGET_W);
    localparam logic [10:0] TARGET_H11 = 11'(TARGET_H);
    localparam logic [7:0]  CD_INIT    = 8'(COOLDOWN_FRAMES);

    state_t      state_r;
    logic        fire_req_r;
    logic [9:0]  laser_x_r;
    logic [9:0]  laser_y_r;
    logic [7:0]  cooldown_r;

    logic        frame_cond_r;
    logic        frame_cond_d_r;
    logic        shoot_r;
    logic        shoot_d_r;

    logic        frame_tick_s;
    logic        shoot_edge_s;
    logic        overlap_s;
    logic        in_box_s;
    logic [10:0] lx_s;
    logic [10:0] ly_s;
    logic [10:0] tx_s;
    logic [10:0] ty_s;
    logic [10:0] px_s;
    logic [10:0] py_s;

    // x/y may sit on the frame point for several clocks; edge detection gives one tick.
    assign frame_tick_s = frame_cond_r & ~frame_cond_d_r;
    assign shoot_edge_s = shoot_r & ~shoot_d_r;

    assign lx_s = {1'b0, laser_x_r};
    assign ly_s = {1'b0, laser_y_r};
    assign tx_s = {1'b0, target_x};
    assign ty_s = {1'b0, target_y};
    assign px_s = {1'b0, x};
    assign py_s = {1'b0, y};

    // Half-open rectangle overlap between laser and target, all in 11 bits.
    assign overlap_s = (lx_s < tx_s + TARGET_W11) && (tx_s < lx_s + LASER_W11) &&
                       (ly_s < ty_s + TARGET_H11) && (ty_s < ly_s + LASER_H11);

    // Current scan pixel lies inside the laser rectangle.
    assign in_box_s = (px_s >= lx_s) && (px_s < lx_s + LASER_W11) &&
                      (py_s >= ly_s) && (py_s < ly_s + LASER_H11);

    // Register the frame-point condition and the shoot button for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cond_r   <= 1'b0;
            frame_cond_d_r <= 1'b0;
            shoot_r        <= 1'b0;
            shoot_d_r      <= 1'b0;
        end else begin
            frame_cond_r   <= (x == 10'd0) && (y == 10'd480);
            frame_cond_d_r <= frame_cond_r;
            shoot_r        <= shoot;
            shoot_d_r      <= shoot_r;
        end
    end

    // Laser state machine: launch, per-frame flight with hit/miss, cooldown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            fire_req_r   <= 1'b0;
            laser_x_r    <= 10'd0;
            laser_y_r    <= 10'd0;
            cooldown_r   <= 8'd0;
            laser_active <= 1'b0;
            hit          <= 1'b0;
            shots_fired  <= 8'd0;
        end else if (!enable) begin
            // Leaving the play screen abandons any shot; the shot counter survives.
            state_r      <= IDLE;
            fire_req_r   <= 1'b0;
            cooldown_r   <= 8'd0;
            laser_active <= 1'b0;
            hit          <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_tick_s && fire_req_r) begin
                        state_r      <= FLYING;
                        fire_req_r   <= 1'b0;
                        laser_active <= 1'b1;
                        laser_x_r    <= ship_x + LAUNCH_DX;
                        laser_y_r    <= (ship_y < LASER_H10) ? 10'd0 : (ship_y - LASER_H10);
                        if (shots_fired != 8'd255) begin
                            shots_fired <= shots_fired + 8'd1;
                        end else begin
                            shots_fired <= shots_fired;
                        end
                    end else if (shoot_edge_s) begin
                        // An edge on the tick itself only arms; launch waits for the next tick.
                        fire_req_r <= 1'b1;
                    end else begin
                        fire_req_r <= fire_req_r;
                    end
                end
                FLYING: begin
                    if (frame_tick_s) begin
                        if (target_alive && overlap_s) begin
                            hit          <= 1'b1;
                            state_r      <= COOLDOWN;
                            cooldown_r   <= CD_INIT;
                            laser_active <= 1'b0;
                        end else if (laser_y_r < SPEED10) begin
                            state_r      <= COOLDOWN;
                            cooldown_r   <= CD_INIT;
                            laser_active <= 1'b0;
                        end else begin
                            laser_y_r <= laser_y_r - SPEED10;
                        end
                    end else begin
                        laser_y_r <= laser_y_r;
                    end
                end
                COOLDOWN: begin
                    if (frame_tick_s) begin
                        // A count of 0 or 1 both release on this tick.
                        if (cooldown_r <= 8'd1) begin
                            state_r    <= IDLE;
                            cooldown_r <= 8'd0;
                        end else begin
                            cooldown_r <= cooldown_r - 8'd1;
                        end
                    end else begin
                        cooldown_r <= cooldown_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    fire_req_r   <= 1'b0;
                    cooldown_r   <= 8'd0;
                    laser_active <= 1'b0;
                end
            endcase
        end
    end

    // Pixel colour, one clock behind x/y, only while the laser is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            laser_color <= 8'd0;
        end else if (enable && (state_r == FLYING) && in_box_s) begin
            laser_color <= LASER_RGB;
        end else begin
            laser_color <= 8'd0;
        end
    end

endmodule

// File: tb/tb_laser_unit.sv
// Self-checking bench for laser_unit: pixel probes through a colour scoreboard,
// plus sequences for flight, hit, cooldown, enable, reset and counter saturation.
module tb_laser_unit;

    logic       clk;
    logic       reset;
    logic [9:0] x, y;
    logic       enable, shoot;
    logic [9:0] ship_x, ship_y, target_x, target_y;
    logic       target_alive;
    logic [7:0] laser_color;
    logic       laser_active, hit;
    logic [7:0] shots_fired;

    logic       enable2, shoot2;
    logic [7:0] laser_color2;
    logic       laser_active2, hit2;
    logic [7:0] shots_fired2;

    int checks = 0;
    int errors = 0;
    int hit_cnt = 0;

    logic [7:0] color_q[$];
    logic       probe_v = 1'b0;
    logic       probe_d = 1'b0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [7:0] exp_color;
    } probe_t;

    probe_t tbl[6];

    laser_unit dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .enable(enable), .shoot(shoot),
        .ship_x(ship_x), .ship_y(ship_y), .target_x(target_x), .target_y(target_y),
        .target_alive(target_alive), .laser_color(laser_color),
        .laser_active(laser_active), .hit(hit), .shots_fired(shots_fired)
    );

    laser_unit #(.COOLDOWN_FRAMES(0)) dut2 (
        .clk(clk), .reset(reset), .x(x), .y(y), .enable(enable2), .shoot(shoot2),
        .ship_x(ship_x), .ship_y(ship_y), .target_x(target_x), .target_y(target_y),
        .target_alive(target_alive), .laser_color(laser_color2),
        .laser_active(laser_active2), .hit(hit2), .shots_fired(shots_fired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: hold the frame point for three clocks, then move off it.
    task automatic frame();
        x = 10'd0; y = 10'd480;
        step(3);
        x = 10'd600; y = 10'd10;
        step(2);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic shoot_pulse();
        shoot = 1'b1;
        step(3);
        shoot = 1'b0;
        step(2);
    endtask

    task automatic shoot2_pulse();
        shoot2 = 1'b1;
        step(3);
        shoot2 = 1'b0;
        step(2);
    endtask

    // Drive one pixel and queue the colour expected one clock later.
    task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic [7:0] ec);
        x = px; y = py;
        color_q.push_back(ec);
        probe_v = 1'b1;
        step(1);
        probe_v = 1'b0;
        x = 10'd600; y = 10'd10;
        step(1);
    endtask

    always @(posedge clk) probe_d <= probe_v;

    // Colour scoreboard: pop and compare on the clock after each probe.
    always @(negedge clk) begin
        if (probe_d) begin
            if (color_q.size() == 0) begin
                check("color_q_underflow", 32'd1, 32'd0);
            end else begin
                check("laser_color", {24'd0, laser_color}, {24'd0, color_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (hit) hit_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ly;
        tbl[0] = '{10'd107, 10'd392, 8'h1C};
        tbl[1] = '{10'd108, 10'd399, 8'h1C};
        tbl[2] = '{10'd109, 10'd392, 8'h00};
        tbl[3] = '{10'd107, 10'd400, 8'h00};
        tbl[4] = '{10'd106, 10'd392, 8'h00};
        tbl[5] = '{10'd107, 10'd391, 8'h00};

        reset = 1'b0; x = 10'd600; y = 10'd10; enable = 1'b0; shoot = 1'b0;
        enable2 = 1'b0; shoot2 = 1'b0;
        ship_x = 10'd100; ship_y = 10'd400; target_x = 10'd300; target_y = 10'd100;
        target_alive = 1'b0;
        step(3);
        check("reset_color", {24'd0, laser_color}, 32'd0);
        check("reset_active", {31'd0, laser_active}, 32'd0);
        check("reset_hit", {31'd0, hit}, 32'd0);
        check("reset_shots", {24'd0, shots_fired}, 32'd0);
        reset = 1'b1;
        step(2);

        // Launch from ship (100,400)
        enable = 1'b1;
        shoot_pulse();
        check("armed_no_launch", {31'd0, laser_active}, 32'd0);
        frame();
        check("launch_active", {31'd0, laser_active}, 32'd1);
        check("launch_shots", {24'd0, shots_fired}, 32'd1);
        for (int i = 0; i < 6; i++) probe(tbl[i].px, tbl[i].py, tbl[i].exp_color);

        // Flight to the top, with ignored shots and ship motion
        for (int n = 1; n <= 98; n++) begin
            if (n == 50) shoot_pulse();
            if (n == 60) ship_x = 10'd200;
            frame();
            ly = 392 - 4 * n;
            probe(10'd107, 10'(ly), 8'h1C);
            probe(10'd107, 10'(ly + 8), 8'h00);
        end
        ship_x = 10'd100;
        check("fly_active_top", {31'd0, laser_active}, 32'd1);
        check("fly_shots_hold", {24'd0, shots_fired}, 32'd1);
        frame();
        check("miss_active", {31'd0, laser_active}, 32'd0);
        check("miss_no_hit", hit_cnt, 32'd0);

        // Cooldown: 15 frames; shots during it are dropped
        shoot_pulse();
        frames(14);
        shoot_pulse();
        frame();
        frame();
        check("cooldown_no_queue", {31'd0, laser_active}, 32'd0);
        check("cooldown_shots", {24'd0, shots_fired}, 32'd1);

        // Hit against target (100,300)
        target_x = 10'd100; target_y = 10'd300; target_alive = 1'b1;
        shoot_pulse();
        frame();
        check("relaunch_shots", {24'd0, shots_fired}, 32'd2);
        frames(20);
        check("pre_hit_active", {31'd0, laser_active}, 32'd1);
        check("pre_hit_count", hit_cnt, 32'd0);
        probe(10'd107, 10'd312, 8'h1C);
        frame();
        check("hit_count", hit_cnt, 32'd1);
        check("hit_active", {31'd0, laser_active}, 32'd0);
        frames(3);
        check("hit_single", hit_cnt, 32'd1);
        frames(12);

        // Same geometry, target dead: passes through
        target_alive = 1'b0;
        shoot_pulse();
        frame();
        check("pass_shots", {24'd0, shots_fired}, 32'd3);
        frames(21);
        check("pass_active", {31'd0, laser_active}, 32'd1);
        check("pass_no_hit", hit_cnt, 32'd1);
        probe(10'd107, 10'd308, 8'h1C);

        // Enable drop mid-flight
        enable = 1'b0;
        step(1);
        check("disable_active", {31'd0, laser_active}, 32'd0);
        probe(10'd107, 10'd308, 8'h00);
        check("disable_shots", {24'd0, shots_fired}, 32'd3);
        target_alive = 1'b1;
        frame();
        check("disable_no_hit", hit_cnt, 32'd1);
        shoot_pulse();
        enable = 1'b1;
        frame();
        check("disabled_shoot_ignored", {31'd0, laser_active}, 32'd0);
        shoot_pulse();
        frame();
        check("reenable_active", {31'd0, laser_active}, 32'd1);
        check("reenable_shots", {24'd0, shots_fired}, 32'd4);

        // Asynchronous reset mid-flight
        reset = 1'b0;
        #1;
        check("async_rst_active", {31'd0, laser_active}, 32'd0);
        check("async_rst_shots", {24'd0, shots_fired}, 32'd0);
        check("async_rst_color", {24'd0, laser_color}, 32'd0);
        step(1);
        reset = 1'b1;
        step(1);

        // Shoot edge on the same clock as the frame tick: launch one frame later
        shoot = 1'b1; x = 10'd0; y = 10'd480;
        step(3);
        shoot = 1'b0; x = 10'd600; y = 10'd10;
        step(2);
        check("same_tick_no_launch", {31'd0, laser_active}, 32'd0);
        frame();
        check("same_tick_launch", {31'd0, laser_active}, 32'd1);
        check("same_tick_shots", {24'd0, shots_fired}, 32'd1);

        // Saturation with zero-length cooldown
        enable = 1'b0;
        ship_y = 10'd0;
        enable2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            shoot2_pulse();
            frames(3);
            if (i == 0) check("sat_first", {24'd0, shots_fired2}, 32'd1);
            if (i == 254) check("sat_255", {24'd0, shots_fired2}, 32'd255);
        end
        check("sat_hold", {24'd0, shots_fired2}, 32'd255);
        check("sat_idle", {31'd0, laser_active2}, 32'd0);

        step(3);
        check("color_q_drained", color_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/laser_unit.md
Name: laser_unit

Overview:
- Player projectile stage for the play screen.
- Fires a vertical laser from the ship's current position on a shoot-button press and advances it upward once per video frame.
- Detects a hit against the current target box and produces the laser pixel colour for the top-level colour OR-mux (RRRGGGBB).
- Sits between the ship/target position sources and the top-level colour mux; its `hit` pulse feeds score logic.

Parameters:
- LASER_W, 2, laser width in pixels
- LASER_H, 8, laser height in pixels
- LASER_SPEED, 4, pixels moved up per frame
- SHIP_W, 16, ship sprite width, used to centre the launch point
- TARGET_W, 16, target box width
- TARGET_H, 16, target box height
- COOLDOWN_FRAMES, 15, frames after a shot ends before the next launch is allowed
- LASER_RGB, 8'b000_111_00, laser pixel colour

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- x  in  10  current VGA pixel column
- y  in  10  current VGA pixel row
- enable  in  1  high while the play screen is active
- shoot  in  1  debounced shoot button, level
- ship_x  in  10  ship top-left x
- ship_y  in  10  ship top-left y
- target_x  in  10  target top-left x
- target_y  in  10  target top-left y
- target_alive  in  1  target may be hit
- laser_color  out  8  laser pixel colour, 0 when not drawing
- laser_active  out  1  high in FLYING
- hit  out  1  one-cycle pulse on target hit
- shots_fired  out  8  launch count, saturating

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, fire_req=0, laser_x=0, laser_y=0, cooldown count=0.
  - laser_color=0, laser_active=0, hit=0, shots_fired=0.
- frame_tick (internal): one-cycle pulse on the rising edge of the registered condition (x==0 && y==480). x/y may hold for several clk cycles; exactly one tick per frame.
- shoot edge: rising edge of registered shoot.
  - Sets fire_req only in IDLE with enable=1.
  - Ignored in FLYING and COOLDOWN; never queued.
- IDLE:
  - On frame_tick with fire_req=1: go to FLYING, clear fire_req, shots_fired += 1 (saturate at 255).
  - Launch position: laser_x = ship_x + SHIP_W/2 - LASER_W/2; laser_y = ship_y - LASER_H.
  - If ship_y < LASER_H, clamp laser_y to 0.
- FLYING, evaluated on frame_tick in this priority:
  1. Hit: target_alive=1 and the rectangles [laser_x, laser_x+LASER_W) x [laser_y, laser_y+LASER_H) and [target_x, target_x+TARGET_W) x [target_y, target_y+TARGET_H) overlap. Then hit=1 for exactly the next clk cycle, go to COOLDOWN, no move.
  2. Miss: laser_y < LASER_SPEED. Go to COOLDOWN (top of screen), no hit.
  3. Otherwise laser_y -= LASER_SPEED.
- Hit test uses the pre-move position. Rectangle comparisons use 11-bit sums; no 10-bit wrap.
- COOLDOWN:
  - Load count with COOLDOWN_FRAMES on entry; decrement on each frame_tick.
  - Go to IDLE on the tick where count==1.
  - COOLDOWN_FRAMES=0 means go to IDLE on the next frame_tick.
- laser_color:
  - Registered, one clk of latency from x/y.
  - Equals LASER_RGB when state==FLYING and laser_x <= x < laser_x+LASER_W and laser_y <= y < laser_y+LASER_H; else 0.
- laser_active: registered, equals (state==FLYING).
- enable low:
  - Synchronously forces IDLE and clears fire_req, laser_active, laser_color and the cooldown count.
  - hit is never asserted while enable is low.
  - shots_fired holds; it is cleared only by reset.
- A shoot edge and a frame_tick in the same cycle in IDLE: fire_req is set that cycle; launch occurs on the following frame_tick.
- Ship motion during flight does not affect laser_x.

Test Plan:
- Launch: enable=1, ship=(100,400), shoot pulse, wait 1 frame -> laser_active=1, laser_x=107, laser_y=392, shots_fired=1; laser_color=8'h1C at pixel (107,392) and (108,399), 0 at (109,392) and (107,400).
- Motion/miss: launch at laser_y=392, target_alive=0 -> laser_y decreases 4 per frame to 0, then COOLDOWN; after 15 frames a new shoot edge launches again (shots_fired=2).
- Hit: ship=(100,400), target=(100,300), target_alive=1 -> hit pulses exactly one clk on the frame where laser_y reaches 312 (overlap with rows 300..315), then laser_active=0; no second pulse; same geometry with target_alive=0 -> no hit, laser passes through.
- Ignored fire: shoot edges during FLYING and COOLDOWN -> shots_fired unchanged; no launch when COOLDOWN exits to IDLE until a fresh edge arrives.
- enable drop mid-flight: enable=0 while FLYING -> next cycle laser_active=0, laser_color=0, no hit; shots_fired retained; re-enable + shoot launches normally.
- Reset mid-flight and saturation: reset low while FLYING -> all outputs 0 immediately; 256 launches with COOLDOWN_FRAMES=0 -> shots_fired stays 255.
